// File: rtl/fpu_issue_tracker_if.sv
// Bus bundle between the stimulus source, the fpnew FPU and the response consumer.
// The tracker connects through the slave modport and the environment through the master modport.
interface fpu_issue_tracker_if #(
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int TAG_W        = 4,
  parameter int OP_W         = 4
);
  // Every channel is valid/ready: a transfer happens on a clk edge where both are high;
  // the sender holds its payload stable while valid is high and ready is low.
  logic                          req_valid;
  logic                          req_ready;
  logic [NUM_OPERANDS*WIDTH-1:0] req_operands;
  logic [OP_W-1:0]               req_op;
  logic                          req_op_mod;
  logic [2:0]                    req_rnd;

  logic                          fpu_in_valid;
  logic                          fpu_in_ready;
  logic [NUM_OPERANDS*WIDTH-1:0] fpu_operands;
  logic [OP_W-1:0]               fpu_op;
  logic                          fpu_op_mod;
  logic [2:0]                    fpu_rnd;
  logic [TAG_W-1:0]              fpu_tag;

  logic                          fpu_out_valid;
  logic                          fpu_out_ready;
  logic [WIDTH-1:0]              fpu_result;
  logic [4:0]                    fpu_status;
  logic [TAG_W-1:0]              fpu_tag_o;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WIDTH-1:0]              rsp_result;
  logic [4:0]                    rsp_status;
  logic [OP_W-1:0]               rsp_op;
  logic [15:0]                   rsp_latency;

  modport slave (
    input  req_valid, req_operands, req_op, req_op_mod, req_rnd,
    output req_ready,
    output fpu_in_valid, fpu_operands, fpu_op, fpu_op_mod, fpu_rnd, fpu_tag,
    input  fpu_in_ready,
    input  fpu_out_valid, fpu_result, fpu_status, fpu_tag_o,
    output fpu_out_ready,
    output rsp_valid, rsp_result, rsp_status, rsp_op, rsp_latency,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_operands, req_op, req_op_mod, req_rnd,
    input  req_ready,
    input  fpu_in_valid, fpu_operands, fpu_op, fpu_op_mod, fpu_rnd, fpu_tag,
    output fpu_in_ready,
    output fpu_out_valid, fpu_result, fpu_status, fpu_tag_o,
    input  fpu_out_ready,
    input  rsp_valid, rsp_result, rsp_status, rsp_op, rsp_latency,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_issue_tracker.sv
// In-order request/response tracker in front of an fpnew FPU: tags issues, bounds in-flight ops,
// checks return order and registers responses. Define FPU_TRK_LATENCY_EN to measure latency.
module fpu_issue_tracker #(
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int TAG_W        = 4,
  parameter int DEPTH        = 8,
  parameter int OP_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  fpu_issue_tracker_if.slave bus,
  output logic               busy,
  output logic               err_order,
  output logic               err_orphan
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OPND_W = NUM_OPERANDS * WIDTH;

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TAG_W-1:0]  issue_tag;
  logic [TAG_W-1:0]  sb_tag [DEPTH];
  logic [OP_W-1:0]   sb_op  [DEPTH];

  logic              not_full;
  logic              out_ready;
  logic              issue_fire;
  logic              ret_fire;
  logic              ret_load;
  logic              ret_orphan;
  logic [15:0]       ret_latency;
  logic [OPND_W-1:0] operands;

  logic              rsp_valid_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic [4:0]        rsp_status_q;
  logic [OP_W-1:0]   rsp_op_q;
  logic [15:0]       rsp_latency_q;
  logic              err_order_q;
  logic              err_orphan_q;

  assign not_full   = count < CNT_W'(DEPTH);
  // A result may always be taken when nothing is outstanding so that stale results drain.
  assign out_ready  = (count == '0) || !rsp_valid_q || bus.rsp_ready;
  assign issue_fire = bus.req_valid && bus.fpu_in_ready && not_full;
  assign ret_fire   = bus.fpu_out_valid && out_ready;
  assign ret_load   = ret_fire && (count != '0);
  assign ret_orphan = ret_fire && (count == '0);

  assign operands          = bus.req_operands;
  assign bus.req_ready     = bus.fpu_in_ready && not_full;
  assign bus.fpu_in_valid  = bus.req_valid && not_full;
  assign bus.fpu_operands  = operands;
  assign bus.fpu_op        = bus.req_op;
  assign bus.fpu_op_mod    = bus.req_op_mod;
  assign bus.fpu_rnd       = bus.req_rnd;
  assign bus.fpu_tag       = issue_tag;
  assign bus.fpu_out_ready = out_ready;

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_latency = rsp_latency_q;

  assign busy       = (count != '0) || rsp_valid_q;
  assign err_order  = err_order_q;
  assign err_orphan = err_orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      issue_tag <= '0;
    end else begin
      if (issue_fire) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        issue_tag <= issue_tag + TAG_W'(1);
      end
      if (ret_load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (issue_fire && !ret_load) begin
        count <= count + CNT_W'(1);
      end else if (!issue_fire && ret_load) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry payload needs no reset: count decides which slots are live.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      sb_tag[wr_ptr] <= issue_tag;
      sb_op[wr_ptr]  <= bus.req_op;
    end
  end

`ifdef FPU_TRK_LATENCY_EN
  logic [15:0] cycle_ctr;
  logic [15:0] sb_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_ctr <= '0;
    end else begin
      cycle_ctr <= cycle_ctr + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      sb_ts[wr_ptr] <= cycle_ctr;
    end
  end

  // Modulo-2^16 subtraction keeps the result right across a counter wrap.
  assign ret_latency = cycle_ctr - sb_ts[rd_ptr];
`else
  assign ret_latency = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_status_q  <= '0;
      rsp_op_q      <= '0;
      rsp_latency_q <= '0;
      err_order_q   <= 1'b0;
      err_orphan_q  <= 1'b0;
    end else begin
      if (ret_load) begin
        rsp_valid_q   <= 1'b1;
        rsp_result_q  <= bus.fpu_result;
        rsp_status_q  <= bus.fpu_status;
        rsp_op_q      <= sb_op[rd_ptr];
        rsp_latency_q <= ret_latency;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (ret_load && (bus.fpu_tag_o != sb_tag[rd_ptr])) begin
        err_order_q <= 1'b1;
      end
      if (ret_orphan) begin
        err_orphan_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_tracker.sv
// Bench for fpu_issue_tracker: directed scenarios then random traffic, checked every cycle
// against a queue-based model of outstanding operations and pending responses.
module tb_fpu_issue_tracker;
  localparam int WIDTH        = 16;
  localparam int NUM_OPERANDS = 3;
  localparam int TAG_W        = 4;
  localparam int DEPTH        = 8;
  localparam int OP_W         = 4;
  localparam int RSP_W        = 5 + OP_W + 16 + WIDTH;
  localparam logic [OP_W-1:0] OP_MUL = 4'd3;
`ifdef FPU_TRK_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0]  op;
    int unsigned      edge_n;
  } entry_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err_order;
  logic err_orphan;

  always #5 clk = ~clk;

  fpu_issue_tracker_if #(
    .WIDTH(WIDTH), .NUM_OPERANDS(NUM_OPERANDS), .TAG_W(TAG_W), .OP_W(OP_W)
  ) bus ();

  fpu_issue_tracker #(
    .WIDTH(WIDTH), .NUM_OPERANDS(NUM_OPERANDS), .TAG_W(TAG_W), .DEPTH(DEPTH), .OP_W(OP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_order (err_order),
    .err_orphan(err_orphan)
  );

  // ---------------- reference model / scoreboard ----------------
  entry_t             inflight[$];
  logic [RSP_W-1:0]   exp_q[$];
  logic [TAG_W-1:0]   next_tag = '0;
  logic               exp_err_order = 1'b0;
  logic               exp_err_orphan = 1'b0;
  int unsigned        edge_n = 0;
  int                 n_assert = 0;
  int                 n_fail = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_req(input logic [OP_W-1:0] op, input logic [NUM_OPERANDS*WIDTH-1:0] opnds);
    bus.req_op       = op;
    bus.req_operands = opnds;
    bus.req_op_mod   = 1'($urandom_range(0, 1));
    bus.req_rnd      = 3'($urandom_range(0, 4));
  endtask

  task automatic set_rand_req();
    set_req(4'($urandom_range(0, 15)),
            {16'($urandom()), 16'($urandom()), 16'($urandom())});
  endtask

  // One clock: drive inputs, check every output against the model, take the edge, advance the model.
  task automatic tick(input logic v, input logic in_rdy, input logic out_v,
                      input logic [TAG_W-1:0] otag, input logic [WIDTH-1:0] res,
                      input logic [4:0] st, input logic r_rdy);
    bit can_issue, out_rdy, issue, ret;
    logic [RSP_W-1:0] head;
    entry_t e;
    logic [15:0] lat;
    bus.req_valid     = v;
    bus.fpu_in_ready  = in_rdy;
    bus.fpu_out_valid = out_v;
    bus.fpu_tag_o     = otag;
    bus.fpu_result    = res;
    bus.fpu_status    = st;
    bus.rsp_ready     = r_rdy;
    #1;
    can_issue = inflight.size() < DEPTH;
    out_rdy   = (inflight.size() == 0) || (exp_q.size() == 0) || r_rdy;
    issue     = v && in_rdy && can_issue;
    ret       = out_v && out_rdy;

    check("req_ready",     64'(bus.req_ready),     64'(in_rdy && can_issue));
    check("fpu_in_valid",  64'(bus.fpu_in_valid),  64'(v && can_issue));
    check("fpu_tag",       64'(bus.fpu_tag),       64'(next_tag));
    check("fpu_operands",  64'(bus.fpu_operands),  64'(bus.req_operands));
    check("fpu_op",        64'(bus.fpu_op),        64'(bus.req_op));
    check("fpu_op_mod",    64'(bus.fpu_op_mod),    64'(bus.req_op_mod));
    check("fpu_rnd",       64'(bus.fpu_rnd),       64'(bus.req_rnd));
    check("fpu_out_ready", 64'(bus.fpu_out_ready), 64'(out_rdy));
    check("rsp_valid",     64'(bus.rsp_valid),     64'(exp_q.size() != 0));
    check("busy",          64'(busy),              64'(inflight.size() != 0 || exp_q.size() != 0));
    check("err_order",     64'(err_order),         64'(exp_err_order));
    check("err_orphan",    64'(err_orphan),        64'(exp_err_orphan));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("rsp_result",  64'(bus.rsp_result),  64'(head[WIDTH-1:0]));
      check("rsp_latency", 64'(bus.rsp_latency), 64'(head[WIDTH+15:WIDTH]));
      check("rsp_op",      64'(bus.rsp_op),      64'(head[WIDTH+16+OP_W-1:WIDTH+16]));
      check("rsp_status",  64'(bus.rsp_status),  64'(head[RSP_W-1:RSP_W-5]));
    end

    @(posedge clk);
    edge_n++;
    if (rst) begin
      inflight.delete();
      exp_q.delete();
      next_tag       = '0;
      exp_err_order  = 1'b0;
      exp_err_orphan = 1'b0;
    end else begin
      if (exp_q.size() != 0 && r_rdy) void'(exp_q.pop_front());
      if (ret) begin
        if (inflight.size() == 0) begin
          exp_err_orphan = 1'b1;
        end else begin
          e = inflight.pop_front();
          if (otag != e.tag) exp_err_order = 1'b1;
          lat = LAT_EN ? 16'(edge_n - e.edge_n) : 16'h0000;
          exp_q.push_back({st, e.op, lat, res});
        end
      end
      if (issue) begin
        inflight.push_back('{tag: next_tag, op: bus.req_op, edge_n: edge_n});
        next_tag = next_tag + TAG_W'(1);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic r_rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, '0, '0, '0, r_rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    check("rst_rsp_valid",   64'(bus.rsp_valid),   64'(0));
    check("rst_rsp_result",  64'(bus.rsp_result),  64'(0));
    check("rst_rsp_status",  64'(bus.rsp_status),  64'(0));
    check("rst_rsp_op",      64'(bus.rsp_op),      64'(0));
    check("rst_rsp_latency", 64'(bus.rsp_latency), 64'(0));
    check("rst_busy",        64'(busy),            64'(0));
    check("rst_err_order",   64'(err_order),       64'(0));
    check("rst_err_orphan",  64'(err_orphan),      64'(0));
    check("rst_fpu_tag",     64'(bus.fpu_tag),     64'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [TAG_W-1:0] t;
    logic v, ir, ov, rr;
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.fpu_in_ready  = 1'b0;
    bus.fpu_out_valid = 1'b0;
    bus.fpu_tag_o     = '0;
    bus.fpu_result    = '0;
    bus.fpu_status    = '0;
    bus.rsp_ready     = 1'b0;
    set_req('0, '0);
    @(posedge clk);
    #1;
    do_reset();

    // Single FP16 multiply 1.0 x 2.0, returned three edges after issue.
    set_req(OP_MUL, {16'h0000, 16'h4000, 16'h3C00});
    check("mul_tag", 64'(bus.fpu_tag), 64'(0));
    tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 4'd0, 16'h4000, 5'd0, 1'b1);
    check("mul_rsp_valid",   64'(bus.rsp_valid),   64'(1));
    check("mul_rsp_result",  64'(bus.rsp_result),  64'(16'h4000));
    check("mul_rsp_op",      64'(bus.rsp_op),      64'(OP_MUL));
    check("mul_rsp_latency", 64'(bus.rsp_latency), LAT_EN ? 64'(3) : 64'(0));
    idle(1, 1'b1);

    // Fill to DEPTH with the FPU stalled; the ninth request waits for the first return.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_rand_req();
      tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    end
    check("full_req_ready",    64'(bus.req_ready),    64'(0));
    check("full_fpu_in_valid", 64'(bus.fpu_in_valid), 64'(0));
    tick(1'b1, 1'b1, 1'b1, 4'd0, 16'($urandom()), 5'($urandom()), 1'b1);
    check("refill_tag",       64'(bus.fpu_tag),   64'(8));
    check("refill_req_ready", 64'(bus.req_ready), 64'(1));
    tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1, 1'b1, TAG_W'(i), 16'($urandom()), 5'($urandom()), 1'b1);
    end
    idle(1, 1'b1);

    // Out-of-order tag: tag 5 returned while tag 4 is at the head.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_rand_req();
      tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1, TAG_W'(i), 16'($urandom()), 5'($urandom()), 1'b1);
    end
    tick(1'b0, 1'b1, 1'b1, 4'd5, 16'h1234, 5'h03, 1'b1);
    check("order_err_order", 64'(err_order),     64'(1));
    check("order_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    idle(2, 1'b1);
    check("order_sticky", 64'(err_order), 64'(1));

    // Result with nothing outstanding.
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF, 5'h1F, 1'b0);
    check("orphan_err",       64'(err_orphan),        64'(1));
    check("orphan_rsp_valid", 64'(bus.rsp_valid),     64'(0));
    check("orphan_out_ready", 64'(bus.fpu_out_ready), 64'(1));
    idle(1, 1'b0);

    // Consumer back-pressure with two returns pending.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_rand_req();
      tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b1, 4'd0, 16'hA5A5, 5'h01, 1'b0);
    bus.fpu_out_valid = 1'b1;
    #1;
    check("bp_out_ready", 64'(bus.fpu_out_ready), 64'(0));
    tick(1'b0, 1'b1, 1'b1, 4'd1, 16'h5A5A, 5'h02, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 4'd1, 16'h5A5A, 5'h02, 1'b0);
    check("bp_hold_result", 64'(bus.rsp_result), 64'(16'hA5A5));
    tick(1'b0, 1'b1, 1'b1, 4'd1, 16'h5A5A, 5'h02, 1'b1);
    check("bp_second_valid",  64'(bus.rsp_valid),  64'(1));
    check("bp_second_result", 64'(bus.rsp_result), 64'(16'h5A5A));
    idle(2, 1'b1);

    // Reset with three operations in flight; their results later arrive as orphans.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_rand_req();
      tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    end
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, TAG_W'(i), 16'($urandom()), 5'($urandom()), 1'b1);
    end
    check("midrst_orphan", 64'(err_orphan), 64'(1));
    check("midrst_tag",    64'(bus.fpu_tag), 64'(0));
    set_rand_req();
    tick(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 4'd0, 16'($urandom()), 5'($urandom()), 1'b1);
    idle(1, 1'b1);

    // Random traffic; the emulated FPU always returns the oldest outstanding tag.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_rand_req();
      v  = ($urandom_range(0, 9) < 6);
      ir = ($urandom_range(0, 9) < 8);
      ov = ($urandom_range(0, 9) < 4);
      rr = ($urandom_range(0, 9) < 7);
      t  = (inflight.size() != 0) ? inflight[0].tag : TAG_W'($urandom());
      tick(v, ir, ov, t, 16'($urandom()), 5'($urandom()), rr);
    end
    while (inflight.size() != 0) begin
      tick(1'b0, 1'b1, 1'b1, inflight[0].tag, 16'($urandom()), 5'($urandom()), 1'b1);
    end
    idle(2, 1'b1);
    check("final_busy",      64'(busy),      64'(0));
    check("final_err_order", 64'(err_order), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
